// File: rtl/nbit_mux_pkg.sv
// ---------------------------------------------------------------------------
// nbit_mux_pkg
//   Shared definitions for the N-channel stream multiplexer.
//   - MODE_FIXED / MODE_RR : encodings of the MODE input.
//   - clog2()              : constant function used to size channel indices.
// ---------------------------------------------------------------------------
package nbit_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Minimum number of bits needed to encode v distinct values (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// ---------------------------------------------------------------------------
// rr_grant_picker
//   Combinational round-robin picker: grants the first requester found when
//   searching ptr, ptr+1, ..., CH-1, 0, ..., ptr-1.
// Ports
//   req        in   CH     request vector
//   ptr        in   SELW   search start index (always < CH)
//   gnt_onehot out  CH     one-hot grant, all zero when nothing requests
//   gnt_idx    out  SELW   index of the granted channel (0 when none)
//   gnt_any    out  1      at least one request was granted
// ---------------------------------------------------------------------------
module rr_grant_picker
    import nbit_mux_pkg::*;
#(
    parameter  int CH   = 4,
    localparam int SELW = clog2(CH)
) (
    input  logic [CH-1:0]   req,
    input  logic [SELW-1:0] ptr,
    output logic [CH-1:0]   gnt_onehot,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [SELW-1:0] idx;

    // NOTE: every output gets a default before the search loop; without it,
    // the no-request path would leave them unassigned and infer latches.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        idx        = '0;
        for (int off = 0; off < CH; off++) begin
            idx = SELW'((int'(ptr) + off) % CH);
            if (!gnt_any && req[idx]) begin
                gnt_any         = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nbit_nx1_stream_mux.sv
// ---------------------------------------------------------------------------
// nbit_nx1_stream_mux
//   Registered CH-to-1 stream multiplexer, N bits per channel, valid/ready on
//   every input and on the output. MODE=0 takes the channel named by S,
//   MODE=1 arbitrates round-robin among valid channels.
// Ports
//   clk       in   1       rising-edge clock
//   nrst      in   1       synchronous active-low reset
//   IN_DATA   in   CH*N    channel k at [k*N +: N]
//   IN_VALID  in   CH      per-channel valid
//   IN_READY  out  CH      per-channel ready, at most one bit high
//   MODE      in   1       0 = fixed select, 1 = round-robin
//   S         in   SELW    channel select for fixed mode
//   Y         out  N       registered output data
//   Y_VALID   out  1       output valid
//   Y_READY   in   1       downstream ready
//   CH_ID     out  SELW    channel that produced the word in Y
// ---------------------------------------------------------------------------
module nbit_nx1_stream_mux
    import nbit_mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int CH   = 4,
    localparam int SELW = clog2(CH)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [CH*N-1:0]   IN_DATA,
    input  logic [CH-1:0]     IN_VALID,
    output logic [CH-1:0]     IN_READY,
    input  logic              MODE,
    input  logic [SELW-1:0]   S,
    output logic [N-1:0]      Y,
    output logic              Y_VALID,
    input  logic              Y_READY,
    output logic [SELW-1:0]   CH_ID
);

    logic [N-1:0]    y_q,       y_d;
    logic            y_valid_q, y_valid_d;
    logic [SELW-1:0] ch_id_q,   ch_id_d;
    logic [SELW-1:0] ptr_q,     ptr_d;

    logic [CH-1:0]   rr_onehot;
    logic [SELW-1:0] rr_idx;
    logic            rr_any;

    logic [CH-1:0]   fix_onehot;
    logic [CH-1:0]   gnt_onehot;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_any;
    logic            load;
    logic            transfer;
    logic [N-1:0]    sel_data;

    rr_grant_picker #(.CH(CH)) u_rr_grant_picker (
        .req        (IN_VALID),
        .ptr        (ptr_q),
        .gnt_onehot (rr_onehot),
        .gnt_idx    (rr_idx),
        .gnt_any    (rr_any)
    );

    // Fixed mode: a select value outside 0..CH-1 matches no channel, so it
    // grants nothing.
    always_comb begin
        fix_onehot = '0;
        for (int k = 0; k < CH; k++) begin
            fix_onehot[k] = (int'(S) == k) && IN_VALID[k];
        end
    end

    always_comb begin
        if (MODE == MODE_RR) begin
            gnt_onehot = rr_onehot;
            gnt_idx    = rr_idx;
            gnt_any    = rr_any;
        end else begin
            gnt_onehot = fix_onehot;
            gnt_idx    = S;
            gnt_any    = |fix_onehot;
        end
    end

    // Output register can accept a word when empty or being drained now.
    // Ready is also forced low while reset is asserted so nothing is
    // consumed upstream in a cycle whose result is discarded.
    assign load     = !y_valid_q || Y_READY;
    assign IN_READY = {CH{load && nrst}} & gnt_onehot;
    assign transfer = load && nrst && gnt_any;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (gnt_onehot[k]) begin
                sel_data = IN_DATA[k*N +: N];
            end
        end
    end

    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        ch_id_d   = ch_id_q;
        ptr_d     = ptr_q;
        if (transfer) begin
            y_d       = sel_data;
            y_valid_d = 1'b1;
            ch_id_d   = gnt_idx;
            if (MODE == MODE_RR) begin
                ptr_d = (gnt_idx == SELW'(CH - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end else if (y_valid_q && Y_READY) begin
            y_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others; reset is synchronous, so it
    // only takes effect on a clock edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            ch_id_q   <= '0;
            ptr_q     <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            ch_id_q   <= ch_id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign Y       = y_q;
    assign Y_VALID = y_valid_q;
    assign CH_ID   = ch_id_q;

endmodule

// File: tb/tb_nbit_nx1_stream_mux.sv
// ---------------------------------------------------------------------------
// tb_nbit_nx1_stream_mux
//   Directed-vector bench for nbit_nx1_stream_mux with N=4, CH=4.
//   Inputs change 1 time unit after a rising edge; combinational ready is
//   checked shortly after that, registered outputs after the next edge.
// ---------------------------------------------------------------------------
module tb_nbit_nx1_stream_mux;

    localparam int N    = 4;
    localparam int CH   = 4;
    localparam int SELW = 2;

    logic            clk;
    logic            nrst;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [N-1:0]    y;
    logic            y_valid;
    logic            y_ready;
    logic [SELW-1:0] ch_id;

    int n_vectors;
    int n_miscompares;

    nbit_nx1_stream_mux #(.N(N), .CH(CH)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .IN_DATA  (in_data),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .MODE     (mode),
        .S        (sel),
        .Y        (y),
        .Y_VALID  (y_valid),
        .Y_READY  (y_ready),
        .CH_ID    (ch_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected round-robin sequences, hand-derived.
    logic [N-1:0]    rr_y   [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    logic [SELW-1:0] rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [N-1:0]    alt_y  [4] = '{4'h2, 4'h4, 4'h2, 4'h4};
    logic [SELW-1:0] alt_id [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;

        // 1. Reset held 3 cycles with every channel valid.
        nrst     = 1'b0;
        in_data  = 16'h4321;
        in_valid = 4'hF;
        mode     = 1'b1;
        sel      = 2'd0;
        y_ready  = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 32'(in_ready), 32'h0);
            tick();
        end
        check("rst_y_valid", 32'(y_valid), 32'h0);
        check("rst_y",       32'(y),       32'h0);
        check("rst_ch_id",   32'(ch_id),   32'h0);
        nrst = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("rel_y",     32'(y),     32'h1);
        check("rel_ch_id", 32'(ch_id), 32'h0);
        // PTR is now 1.

        // 2. Fixed select S=2 with ch2 carrying 0xA.
        mode    = 1'b0;
        sel     = 2'd2;
        in_data = 16'h4A21;
        #1;
        check("fix_in_ready", 32'(in_ready), 32'h4);
        tick();
        check("fix_y",       32'(y),       32'hA);
        check("fix_ch_id",   32'(ch_id),   32'h2);
        check("fix_y_valid", 32'(y_valid), 32'h1);
        sel      = 2'd3;
        in_valid = 4'b0111;
        #1;
        check("fix_s3_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("fix_drain_y_valid", 32'(y_valid), 32'h0);
        check("fix_drain_y_hold",  32'(y),       32'hA);
        check("fix_drain_ch_hold", 32'(ch_id),   32'h2);

        // 3. Round-robin from PTR=0 (short reset to restart the pointer).
        nrst = 1'b0;
        tick();
        nrst     = 1'b1;
        mode     = 1'b1;
        in_data  = 16'h4321;
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_y",       32'(y),       32'(rr_y[i]));
            check("rr_ch_id",   32'(ch_id),   32'(rr_id[i]));
            check("rr_y_valid", 32'(y_valid), 32'h1);
        end
        // PTR is now 1; only ch1 and ch3 request.
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_y",     32'(y),     32'(alt_y[i]));
            check("alt_ch_id", 32'(ch_id), 32'(alt_id[i]));
        end
        // PTR is now 0.

        // 4. Backpressure while holding 0x5 from ch0.
        in_data  = 16'h4325;
        in_valid = 4'b0001;
        tick();
        check("bp_load_y", 32'(y), 32'h5);
        // PTR is now 1.
        y_ready  = 1'b0;
        in_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            check("bp_y",       32'(y),       32'h5);
            check("bp_y_valid", 32'(y_valid), 32'h1);
        end
        in_data  = 16'h4327;
        in_valid = 4'b0001;
        y_ready  = 1'b1;
        #1;
        check("bp_rel_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("bp_rel_y",       32'(y),       32'h7);
        check("bp_rel_y_valid", 32'(y_valid), 32'h1);
        // PTR is now 1.

        // 5. Mode switch mid-stream: RR grants ch1, two fixed words, RR again.
        in_valid = 4'hF;
        tick();
        check("ms_rr_ch_id", 32'(ch_id), 32'h1);
        check("ms_rr_y",     32'(y),     32'h2);
        mode = 1'b0;
        sel  = 2'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("ms_fix_ch_id", 32'(ch_id), 32'h0);
            check("ms_fix_y",     32'(y),     32'h7);
        end
        mode = 1'b1;
        #1;
        check("ms_resume_in_ready", 32'(in_ready), 32'h4);
        tick();
        check("ms_resume_ch_id", 32'(ch_id), 32'h2);
        check("ms_resume_y",     32'(y),     32'h3);
        // PTR is now 3.

        // 6. Reset for one cycle while Y holds a word and ch3 is valid.
        in_valid = 4'b1000;
        nrst     = 1'b0;
        #1;
        check("mr_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("mr_y_valid", 32'(y_valid), 32'h0);
        check("mr_y",       32'(y),       32'h0);
        check("mr_ch_id",   32'(ch_id),   32'h0);
        nrst     = 1'b1;
        in_valid = 4'hF;
        #1;
        check("mr_ptr_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("mr_after_y",     32'(y),     32'h7);
        check("mr_after_ch_id", 32'(ch_id), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
